// File: rtl/gpio_ctrl_if.sv
// Peripheral bus interface for gpio_ctrl: single-beat request, one-cycle read response.
interface gpio_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [3:0]  req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO controller: output data/enable, atomic set/clear, synchronised input, rise/fall IRQs.
// Optional per-pin input debounce enabled by defining GPIO_DEBOUNCE_EN.
module gpio_ctrl #(
   parameter int unsigned NR_GPIOS        = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset_,
   gpio_ctrl_if.slave          bus,
   output logic [NR_GPIOS-1:0] gpio_oe,
   output logic [NR_GPIOS-1:0] gpio_do,
   input  logic [NR_GPIOS-1:0] gpio_di,
   output logic                irq
);

   typedef enum logic [3:0] {
      A_DATA_OUT   = 4'd0,
      A_OE         = 4'd1,
      A_DATA_IN    = 4'd2,
      A_SET        = 4'd3,
      A_CLR        = 4'd4,
      A_RISE_EN    = 4'd5,
      A_FALL_EN    = 4'd6,
      A_IRQ_STATUS = 4'd7
   } reg_addr_e;

   logic [NR_GPIOS-1:0] data_out, oe, rise_en, fall_en, irq_status;
   logic [NR_GPIOS-1:0] sync1, sync2, filt, prev;
   logic [NR_GPIOS-1:0] wd, w1c, rise, fall;
   logic [1:0]          warm;
   logic                edges_en;
   logic                wr_acc, rd_acc;
   logic [31:0]         rd_word;
   logic                rsp_valid_q;
   logic [31:0]         rsp_rdata_q;
   logic                unused_wdata;

   assign bus.req_ready = 1'b1;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign gpio_do       = data_out;
   assign gpio_oe       = oe;

   assign wr_acc       = bus.req_valid & bus.req_wr;
   assign rd_acc       = bus.req_valid & ~bus.req_wr;
   assign wd           = bus.req_wdata[NR_GPIOS-1:0];
   assign unused_wdata = ^bus.req_wdata;

   always_ff @(posedge clk) begin
      if (!reset_) begin
         data_out <= '0;
         oe       <= '0;
         rise_en  <= '0;
         fall_en  <= '0;
      end else if (wr_acc) begin
         case (bus.req_addr)
            A_DATA_OUT: data_out <= wd;
            A_OE:       oe       <= wd;
            A_SET:      data_out <= data_out | wd;
            A_CLR:      data_out <= data_out & ~wd;
            A_RISE_EN:  rise_en  <= wd;
            A_FALL_EN:  fall_en  <= wd;
            default:    ;
         endcase
      end
   end

   always_comb begin
      rd_word = '0;
      case (bus.req_addr)
         A_DATA_OUT:   rd_word[NR_GPIOS-1:0] = data_out;
         A_OE:         rd_word[NR_GPIOS-1:0] = oe;
         A_DATA_IN:    rd_word[NR_GPIOS-1:0] = filt;
         A_RISE_EN:    rd_word[NR_GPIOS-1:0] = rise_en;
         A_FALL_EN:    rd_word[NR_GPIOS-1:0] = fall_en;
         A_IRQ_STATUS: rd_word[NR_GPIOS-1:0] = irq_status;
         default:      rd_word = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= rd_acc;
         if (rd_acc)
            rsp_rdata_q <= rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= gpio_di;
         sync2 <= sync1;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [CW-1:0] cnt [NR_GPIOS];

   // filt only follows sync after DEBOUNCE_CYCLES consecutive cycles of disagreement
   always_ff @(posedge clk) begin
      if (!reset_) begin
         filt <= '0;
         for (int unsigned i = 0; i < NR_GPIOS; i++)
            cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NR_GPIOS; i++) begin
            if (cnt[i] == CW'(DEBOUNCE_CYCLES)) begin
               filt[i] <= sync2[i];
               cnt[i]  <= '0;
            end else if (sync2[i] != filt[i]) begin
               cnt[i] <= cnt[i] + CW'(1);
            end else begin
               cnt[i] <= '0;
            end
         end
      end
   end
`else
   localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;
   assign filt = sync2;
`endif

   // Edges are suppressed until the synchroniser and prev have flushed their reset zeros
   always_ff @(posedge clk) begin
      if (!reset_) begin
         prev <= '0;
         warm <= '0;
      end else begin
         prev <= filt;
         if (warm != 2'd3)
            warm <= warm + 2'd1;
      end
   end

   assign edges_en = (warm == 2'd3);
   assign rise     = edges_en ? (filt & ~prev & rise_en) : '0;
   assign fall     = edges_en ? (~filt & prev & fall_en) : '0;
   assign w1c      = (wr_acc && bus.req_addr == A_IRQ_STATUS) ? wd : '0;

   always_ff @(posedge clk) begin
      if (!reset_) begin
         irq_status <= '0;
         irq        <= 1'b0;
      end else begin
         irq_status <= (irq_status & ~w1c) | rise | fall;
         irq        <= |irq_status;
      end
   end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (8-pin and 32-pin instances), read scoreboard per bus.
module tb_gpio_ctrl;

`ifdef GPIO_DEBOUNCE_EN
   localparam int IN_LAT = 2 + 4 + 1;
`else
   localparam int IN_LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        reset_;
   logic [7:0]  gpio_oe, gpio_do, gpio_di;
   logic        irq;
   logic [31:0] gpio_oe32, gpio_do32, gpio_di32;
   logic        irq32;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [31:0] q8[$];
   logic [31:0] q32[$];

   gpio_ctrl_if bus8 ();
   gpio_ctrl_if bus32 ();

   gpio_ctrl #(.NR_GPIOS(8), .DEBOUNCE_CYCLES(4)) dut8 (
      .clk(clk), .reset_(reset_), .bus(bus8.slave),
      .gpio_oe(gpio_oe), .gpio_do(gpio_do), .gpio_di(gpio_di), .irq(irq)
   );

   gpio_ctrl #(.NR_GPIOS(32), .DEBOUNCE_CYCLES(4)) dut32 (
      .clk(clk), .reset_(reset_), .bus(bus32.slave),
      .gpio_oe(gpio_oe32), .gpio_do(gpio_do32), .gpio_di(gpio_di32), .irq(irq32)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input bit big, input logic [3:0] a, input logic [31:0] d);
      if (big) begin
         bus32.req_valid = 1'b1; bus32.req_wr = 1'b1; bus32.req_addr = a; bus32.req_wdata = d;
      end else begin
         bus8.req_valid = 1'b1; bus8.req_wr = 1'b1; bus8.req_addr = a; bus8.req_wdata = d;
      end
      @(negedge clk);
      bus8.req_valid  = 1'b0;
      bus32.req_valid = 1'b0;
   endtask

   task automatic rd(input bit big, input logic [3:0] a, input logic [31:0] e);
      if (big) begin
         bus32.req_valid = 1'b1; bus32.req_wr = 1'b0; bus32.req_addr = a; bus32.req_wdata = '0;
         q32.push_back(e);
      end else begin
         bus8.req_valid = 1'b1; bus8.req_wr = 1'b0; bus8.req_addr = a; bus8.req_wdata = '0;
         q8.push_back(e);
      end
      @(negedge clk);
      bus8.req_valid  = 1'b0;
      bus32.req_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (bus8.rsp_valid === 1'b1) begin
         if (q8.size() == 0) check("rsp8_unexpected", 32'(bus8.rsp_valid), 32'd0);
         else                check("rsp8_rdata", bus8.rsp_rdata, q8.pop_front());
      end
      if (bus32.rsp_valid === 1'b1) begin
         if (q32.size() == 0) check("rsp32_unexpected", 32'(bus32.rsp_valid), 32'd0);
         else                 check("rsp32_rdata", bus32.rsp_rdata, q32.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_ = 1'b0;
      gpio_di = 8'hFF;
      gpio_di32 = '0;
      bus8.req_valid = 1'b0;  bus8.req_wr = 1'b0;  bus8.req_addr = '0;  bus8.req_wdata = '0;
      bus32.req_valid = 1'b0; bus32.req_wr = 1'b0; bus32.req_addr = '0; bus32.req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_oe", 32'(gpio_oe), 32'h0);
      check("rst_do", 32'(gpio_do), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_rsp_valid", 32'(bus8.rsp_valid), 32'h0);
      check("rst_rsp_rdata", bus8.rsp_rdata, 32'h0);
      check("rst_do32", gpio_do32, 32'h0);

      // High pins through reset must not produce rise events
      reset_ = 1'b1;
`ifdef GPIO_DEBOUNCE_EN
      repeat (12) @(negedge clk);
`endif
      wr(0, 4'd5, 32'hFF);
      repeat (12) @(negedge clk);
      check("warm_irq", 32'(irq), 32'h0);
      rd(0, 4'd7, 32'h00);
      rd(0, 4'd2, 32'hFF);

      gpio_di = 8'hF7;
      repeat (12) @(negedge clk);
      rd(0, 4'd2, 32'hF7);
      rd(0, 4'd7, 32'h00);
      gpio_di = 8'hFF;
      repeat (12) @(negedge clk);
      rd(0, 4'd7, 32'h08);
      check("rise_irq", 32'(irq), 32'h1);

      wr(0, 4'd7, 32'h08);
      wr(0, 4'd5, 32'h00);
      wr(0, 4'd6, 32'h01);
      repeat (3) @(negedge clk);
      check("w1c_irq", 32'(irq), 32'h0);
      gpio_di = 8'hFE;
      repeat (12) @(negedge clk);
      rd(0, 4'd7, 32'h01);
      rd(0, 4'd2, 32'hFE);
      gpio_di = 8'hFF;
      repeat (12) @(negedge clk);
      rd(0, 4'd7, 32'h01);

      // w1c accepted on the very edge where the new fall is seen
      gpio_di = 8'hFE;
      repeat (IN_LAT) @(negedge clk);
      wr(0, 4'd7, 32'h01);
      rd(0, 4'd7, 32'h01);
      wr(0, 4'd7, 32'h01);
      check("irq_lag", 32'(irq), 32'h1);
      @(negedge clk);
      check("irq_clear", 32'(irq), 32'h0);
      rd(0, 4'd7, 32'h00);

      wr(0, 4'd1, 32'hFF);
      check("oe_ff", 32'(gpio_oe), 32'hFF);
      wr(0, 4'd0, 32'hA5);
      check("do_a5", 32'(gpio_do), 32'hA5);
      wr(0, 4'd3, 32'h02);
      check("do_set", 32'(gpio_do), 32'hA7);
      wr(0, 4'd4, 32'h80);
      check("do_clr", 32'(gpio_do), 32'h27);
      rd(0, 4'd0, 32'h27);
      rd(0, 4'd1, 32'hFF);
      rd(0, 4'd3, 32'h0);
      rd(0, 4'd4, 32'h0);
      rd(0, 4'd12, 32'h0);
      wr(0, 4'd12, 32'hFFFF_FFFF);
      rd(0, 4'd0, 32'h27);
      rd(0, 4'd1, 32'hFF);
      rd(0, 4'd5, 32'h00);
      rd(0, 4'd6, 32'h01);
      rd(0, 4'd7, 32'h00);
      check("do_after_unmapped", 32'(gpio_do), 32'h27);
      wr(0, 4'd0, 32'hFFFF_FF5A);
      check("do_upper_ignored", 32'(gpio_do), 32'h5A);
      rd(0, 4'd0, 32'h5A);

      wr(1, 4'd0, 32'hFFFF_FFFF);
      check("do32_ones", gpio_do32, 32'hFFFF_FFFF);
      wr(1, 4'd4, 32'h8000_0001);
      check("do32_clr", gpio_do32, 32'h7FFF_FFFE);
      rd(1, 4'd0, 32'h7FFF_FFFE);
      rd(1, 4'd2, 32'h0);

      gpio_di = 8'h00;
      repeat (20) @(negedge clk);
      wr(0, 4'd7, 32'hFF);
      wr(0, 4'd6, 32'h00);
      wr(0, 4'd5, 32'h02);
      repeat (2) @(negedge clk);
`ifdef GPIO_DEBOUNCE_EN
      gpio_di = 8'h02;
      repeat (3) @(negedge clk);
      gpio_di = 8'h00;
      repeat (15) @(negedge clk);
      rd(0, 4'd2, 32'h00);
      rd(0, 4'd7, 32'h00);
      check("glitch_irq", 32'(irq), 32'h0);
`endif
      // Reads straddle the exact edge where DATA_IN[1] takes the new value
      gpio_di = 8'h02;
      repeat (IN_LAT - 2) @(negedge clk);
      rd(0, 4'd2, 32'h00);
      rd(0, 4'd2, 32'h00);
      rd(0, 4'd2, 32'h02);
      repeat (10 - (IN_LAT + 1)) @(negedge clk);
      gpio_di = 8'h00;
      repeat (15) @(negedge clk);
      rd(0, 4'd7, 32'h02);
      rd(0, 4'd2, 32'h00);
      check("pulse_irq", 32'(irq), 32'h1);

      // Read issued on a reset edge must not produce a response
      reset_ = 1'b0;
      bus8.req_valid = 1'b1; bus8.req_wr = 1'b0; bus8.req_addr = 4'd0;
      @(negedge clk);
      bus8.req_valid = 1'b0;
      check("rst2_rsp_valid", 32'(bus8.rsp_valid), 32'h0);
      check("rst2_rsp_rdata", bus8.rsp_rdata, 32'h0);
      check("rst2_do", 32'(gpio_do), 32'h0);
      check("rst2_oe", 32'(gpio_oe), 32'h0);
      check("rst2_irq", 32'(irq), 32'h0);
      check("rst2_do32", gpio_do32, 32'h0);
      reset_ = 1'b1;
      repeat (3) @(negedge clk);
      check("q8_drained", 32'(q8.size()), 32'd0);
      check("q32_drained", 32'(q32.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Parametrised GPIO controller. Successor to the fixed 8-bit GPIO path between the SoC and its pad_inout cells.
- Provides per-pin output data, output enable and synchronised input, with atomic set/clear and per-pin rise/fall interrupts.
- Sits on the SoC peripheral bus. gpio_oe, gpio_do and gpio_di connect to an array of pad_inout cells at top level.

Parameters:
NR_GPIOS, 8, number of pins; legal range 1..32
DEBOUNCE_CYCLES, 4, consecutive stable cycles before an input change is accepted; only used with GPIO_DEBOUNCE_EN; legal range >= 1

Ports:
clk  input  1  system clock
reset_  input  1  reset; synchronous, active-low
req_valid  input  1  bus request valid
req_ready  output  1  bus request accepted; tied high
req_wr  input  1  1 = write, 0 = read
req_addr  input  4  word address
req_wdata  input  32  write data
rsp_valid  output  1  read data valid
rsp_rdata  output  32  read data
gpio_oe  output  NR_GPIOS  pad output enable
gpio_do  output  NR_GPIOS  pad output data
gpio_di  input  NR_GPIOS  pad input data; asynchronous
irq  output  1  level interrupt; OR of IRQ_STATUS

Behaviour:
- Reset (reset_ = 0 at a clk edge) clears, on that edge, all of the following to 0:
  - outputs gpio_oe, gpio_do, rsp_valid, rsp_rdata, irq;
  - registers RISE_EN, FALL_EN, IRQ_STATUS;
  - the synchroniser, previous-value and warm-up registers.
- Register map (word address), bits [NR_GPIOS-1:0]; upper bits read 0 and are ignored on write:
  - 0 DATA_OUT rw, drives gpio_do
  - 1 OE rw, drives gpio_oe
  - 2 DATA_IN ro, filtered input
  - 3 SET wo, DATA_OUT |= wdata; reads 0
  - 4 CLR wo, DATA_OUT &= ~wdata; reads 0
  - 5 RISE_EN rw
  - 6 FALL_EN rw
  - 7 IRQ_STATUS rw1c
  - Addresses 8..15: reads return 0, writes are ignored.
- Bus transfer occurs when req_valid = 1 (req_ready is constantly 1).
  - Write: takes effect on that edge; gpio_do/gpio_oe change in the next cycle.
  - Read: rsp_valid = 1 for exactly one cycle, the cycle after acceptance, with rsp_rdata. rsp_rdata holds its value otherwise.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses.
- Input path:
  - gpio_di passes through a 2-flop synchroniser to give sync.
  - Filtered value filt = sync (no debounce).
  - DATA_IN reflects a gpio_di change 2 cycles later without debounce.
- Edge detect:
  - prev <= filt every cycle.
  - rise = filt & ~prev & RISE_EN; fall = ~filt & prev & FALL_EN.
  - Gated off until a 2-bit warm-up counter saturates at 3, counted in cycles after reset release. This prevents spurious edges from a high pin at reset.
- IRQ_STATUS next state = (IRQ_STATUS & ~w1c_mask) | rise | fall.
  - A new edge in the same cycle as a w1c of that bit: set wins.
  - irq is registered: irq = |IRQ_STATUS, one cycle after the status update.
- Simultaneous writes to SET and CLR cannot occur (single port).
- Disabling RISE_EN/FALL_EN does not clear pending status.
- Reset mid-transfer: a pending rsp_valid is dropped, i.e. 0 on the cycle after the reset edge.

Optional Feature:
- Macro GPIO_DEBOUNCE_EN.
- Defined:
  - Each pin has a counter of $clog2(DEBOUNCE_CYCLES+1) bits.
  - When sync != filt, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES, filt <= sync and the counter clears.
  - Input-to-DATA_IN latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Glitches shorter than DEBOUNCE_CYCLES never reach filt and raise no IRQ.
- Undefined: filt = sync. No counters are synthesised; DEBOUNCE_CYCLES is unused.

Test Plan:
- Reset, then write OE = 0xFF, DATA_OUT = 0xA5, SET = 0x02, CLR = 0x80:
  - gpio_oe = 0xFF;
  - gpio_do goes 0xA5 -> 0xA7 -> 0x27, each one cycle after its write;
  - read addr 0 returns 0x27 with rsp_valid one cycle after the request.
- gpio_di = 0xFF held through reset, RISE_EN = 0xFF:
  - IRQ_STATUS stays 0 and irq stays 0 after reset release.
  - Then drop pin 3 to 0 and raise it again with RISE_EN[3] = 1: IRQ_STATUS = 0x08 and irq = 1.
- FALL_EN = 0x01, pin 0 1 -> 0:
  - IRQ_STATUS = 0x01.
  - Write IRQ_STATUS = 0x01 in the same cycle as a new fall on pin 0: bit stays 1.
  - A later w1c with no edge clears it, and irq = 0 next cycle.
- Read addresses 3, 4 and 12, and write address 12: all reads return 0 and no register changes.
- With NR_GPIOS = 32:
  - write DATA_OUT = 0xFFFFFFFF, then CLR = 0x80000001;
  - read returns 0x7FFFFFFE.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES = 4:
  - a 3-cycle high pulse on pin 1 leaves DATA_IN = 0 and raises no IRQ;
  - a 10-cycle high pulse sets DATA_IN[1] = 1 exactly 7 cycles after the gpio_di change.
